// File: rtl/unidir_bus_driver_if.sv
// rtl/unidir_bus_driver_if.sv - producer handshake and 4-bit bus signals for unidir_bus_driver
interface unidir_bus_driver_if;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] bus_inp;
    logic       bus_c;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  bus_inp,
        input  bus_c
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output bus_inp,
        output bus_c
    );
endinterface

// File: rtl/unidir_bus_driver.sv
// rtl/unidir_bus_driver.sv - FIFO-buffered framer driving bus_inp/bus_c; UBUS_SENT_CNT_EN adds sent_cnt
module unidir_bus_driver #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    unidir_bus_driver_if.slave       bus,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
`ifdef UBUS_SENT_CNT_EN
    ,
    output logic [7:0]               sent_cnt
`endif
);
    localparam int AW     = $clog2(DEPTH);
    localparam int CNTW   = AW + 1;
    localparam int MAXT   = (HOLD > GAP) ? HOLD : GAP;
    localparam int TW     = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam bit NO_GAP = (GAP == 0);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRIVE, S_GAP} state_t;

    state_t          state;
    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   tmr;
    logic [3:0]      bus_inp_r;
    logic            bus_c_r;
    logic            push;
    logic            pop;
    logic            tmr_done;
    logic            has_word;

    assign bus.in_ready = (count < CNTW'(DEPTH));
    assign bus.bus_inp  = bus_inp_r;
    assign bus.bus_c    = bus_c_r;
    assign busy         = (state != S_IDLE) || has_word;

    assign has_word = (count != '0);
    assign tmr_done = (tmr == '0);
    assign push     = bus.in_valid && bus.in_ready;
    // A pop is exactly an entry into SETUP, from whichever state ends a frame.
    assign pop      = has_word &&
                      ((state == S_IDLE) ||
                       (state == S_DRIVE && tmr_done && NO_GAP) ||
                       (state == S_GAP   && tmr_done));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tmr       <= '0;
            bus_inp_r <= '0;
            bus_c_r   <= 1'b0;
        end else if (pop) begin
            state     <= S_SETUP;
            bus_inp_r <= mem[rd_ptr];
            bus_c_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus_c_r <= 1'b0;
                end
                S_SETUP: begin
                    state   <= S_DRIVE;
                    bus_c_r <= 1'b1;
                    tmr     <= TW'(HOLD - 1);
                end
                S_DRIVE: begin
                    if (!tmr_done) begin
                        tmr <= tmr - 1'b1;
                    end else if (!NO_GAP) begin
                        state   <= S_GAP;
                        bus_c_r <= 1'b0;
                        tmr     <= TW'(GAP - 1);
                    end else begin
                        state   <= S_IDLE;
                        bus_c_r <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (!tmr_done) begin
                        tmr <= tmr - 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    bus_c_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef UBUS_SENT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_cnt <= '0;
        end else if (state == S_DRIVE && tmr_done) begin
            sent_cnt <= sent_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: doc/unidir_bus_driver.md
# unidir_bus_driver

Upstream feeder for the 4-bit unidirectional bus. It buffers 4-bit words from a producer in a small FIFO and sequences each word onto the bus as a fixed frame: data set up with the bus enable low, enable high for a programmable hold, then an optional idle gap. It generates the `inp`/`c` pair that the bus stage consumes and replaces hand-written stimulus with a clocked, back-pressured source.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- HOLD, 2, cycles `bus_c` stays high per word; minimum 1.
- GAP, 1, idle cycles with `bus_c` low after each word; 0 allowed.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  4  word from producer.
- in_valid  in  1  producer offers `in_data`.
- in_ready  out  1  FIFO can accept; high when `count < DEPTH`.
- bus_inp  out  4  bus data, drives the bus stage's `inp`.
- bus_c  out  1  bus enable, drives the bus stage's `c`.
- busy  out  1  high when state != IDLE or `count != 0`.
- count  out  $clog2(DEPTH)+1  words currently queued, excluding the word on the bus.
- sent_cnt  out  8  words completed; present only with `UBUS_SENT_CNT_EN`.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes `in_data` at the write pointer.
- Pop: occurs on entry to SETUP. The head word is loaded into the `bus_inp` register and the read pointer advances.
- Pointers wrap modulo DEPTH.
- Push and pop on the same edge leave `count` unchanged.
- When the FIFO is full, `in_ready` is low. A same-cycle pop does not raise it (no pass-through).
- FSM states: IDLE, SETUP, DRIVE, GAP. A hold/gap counter is reloaded on each state entry.
- IDLE: `bus_c`=0. If `count != 0`, go to SETUP with a pop.
- SETUP: 1 cycle, `bus_c`=0, new data stable, then go to DRIVE.
- DRIVE: HOLD cycles with `bus_c`=1. On exit:
  - if GAP > 0, go to GAP;
  - else if `count != 0`, go to SETUP with a pop;
  - else go to IDLE.
- GAP: GAP cycles with `bus_c`=0. On exit, go to SETUP with a pop if `count != 0`, else IDLE.
- `bus_inp` changes only on SETUP entry. It holds the last word in GAP and IDLE.
- Words appear on the bus in exact push order. No loss, no duplication.
- Pushes during DRIVE or GAP are queued and never disturb the word currently on the bus.

## Timing
- Reset values: `bus_inp`=0, `bus_c`=0, `in_ready`=1, `busy`=0, `count`=0, `sent_cnt`=0, state IDLE.
- Reset acts immediately without a clock. FIFO contents and any in-flight word are discarded.
- Latency: a word pushed at edge N into an empty, IDLE block reaches `bus_inp` after edge N+1 (SETUP).
- `bus_c` is high after edges N+2 through N+1+HOLD.
- Per-word bus period is 1+HOLD+GAP cycles. Back-to-back words need no IDLE cycle.
- All outputs are registered except `in_ready` and `busy`, which decode directly from registered `count` and state.
- `count` max is DEPTH. Pushes while `in_ready`=0 are ignored and `count` is unchanged.

## Configuration
- `UBUS_SENT_CNT_EN` defined: adds the `sent_cnt` port and register.
  - Increments by 1 on the last DRIVE cycle of each word.
  - Wraps 255 -> 0.
  - Resets to 0.
- `UBUS_SENT_CNT_EN` undefined: no port, no register. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0, then release -> `bus_inp`=0, `bus_c`=0, `in_ready`=1, `busy`=0, `count`=0.
- Single word (HOLD=2, GAP=1): push 4'hA at edge N -> `bus_inp`=A with `bus_c`=0 after N+1, `bus_c`=1 after N+2 and N+3, `bus_c`=0 after N+4, IDLE and `busy`=0 after N+5.
- Sweep: push 0..15 with `in_valid` held high ->
  - `in_ready` drops whenever `count`=4;
  - `bus_inp` presents 0,1,...,15 in order, each with exactly 2 `bus_c`-high cycles;
  - `count` returns to 0.
- Simultaneous push/pop: `count`=3 and a push on the edge entering SETUP -> `count` stays 3; the popped word is the oldest.
- Full: fill to 4 during DRIVE and keep `in_valid` high -> extra words are not accepted and `count`=4 until the next pop.
- Reset during DRIVE: drop rst_n mid-hold -> `bus_c`=0 and `count`=0 immediately. After release, a push of 4'h5 produces the normal single-word frame.
- Macro (`UBUS_SENT_CNT_EN`): send 256 words -> `sent_cnt` counts 1..255, then reads 0 after the 256th.
